micro_sequencer: RTL and testbench

Parametrised microprogrammed sequencer that generalises the fixed-width SPARC control unit. It has configurable state width, control-word width and condition count, an eight-way next-address mode with conditional wait and branch, a micro-subroutine call/return stack and a global hold. It drives an external asynchronous microstore and registers the returned microword into a pipeline control register. It sits between the instruction encoder (dispatch address), the datapath/memory status flags (conditions) and the datapath control inputs.

---
 rtl/micro_sequencer.sv | 169 ++++++++++++++++
 tb/tb_micro_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Microprogrammed sequencer: selects the next micro-address from an eight-way mode field,
// registers the returned microword, and keeps a small micro-subroutine return stack.
module micro_sequencer #(
    parameter int unsigned SW          = 5,
    parameter int unsigned CW          = 28,
    parameter int unsigned NCOND       = 4,
    parameter int unsigned CSW         = 2,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned FETCH_STATE = 1,
    parameter int unsigned RESET_STATE = 0
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           hold,
    input  logic [SW-1:0]                  dispatch_addr,
    input  logic [NCOND-1:0]               cond,
    input  logic [CW-1:0]                  uw_ctrl,
    input  logic [2:0]                     uw_ns,
    input  logic [CSW-1:0]                 uw_csel,
    input  logic                           uw_inv,
    input  logic [SW-1:0]                  uw_cr,
    output logic [SW-1:0]                  rom_addr,
    output logic [SW-1:0]                  present_state,
    output logic [CW-1:0]                  ctrl,
    output logic [$clog2(DEPTH+1)-1:0]     stack_level,
    output logic                           stk_ovf,
    output logic                           stk_unf
);

    localparam int unsigned SPW = $clog2(DEPTH + 1);
    localparam int unsigned NCE = 1 << CSW;

    localparam logic [2:0] NS_DISPATCH = 3'b000;
    localparam logic [2:0] NS_FETCH    = 3'b001;
    localparam logic [2:0] NS_JUMP     = 3'b010;
    localparam logic [2:0] NS_INC      = 3'b011;
    localparam logic [2:0] NS_BRANCH   = 3'b100;
    localparam logic [2:0] NS_WAIT     = 3'b101;
    localparam logic [2:0] NS_CALL     = 3'b110;
    localparam logic [2:0] NS_RET      = 3'b111;

    logic [SW-1:0]  present_state_q, present_state_d;
    logic [CW-1:0]  ctrl_q, ctrl_d;
    logic [2:0]     ns_q, ns_d;
    logic [CSW-1:0] csel_q, csel_d;
    logic           inv_q, inv_d;
    logic [SW-1:0]  cr_q, cr_d;
    logic [SW-1:0]  stack_q [DEPTH];
    logic [SW-1:0]  stack_d [DEPTH];
    logic [SPW-1:0] sp_q, sp_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;

    logic [NCE-1:0] cond_ext;
    logic           c;
    logic [SW-1:0]  inc;
    logic [SW-1:0]  top;
    logic           full;
    logic           empty;

    // Unpopulated condition selects read as 0 before the invert.
    assign cond_ext = NCE'(cond);
    assign c        = cond_ext[csel_q] ^ inv_q;
    assign inc      = present_state_q + SW'(1);
    assign full     = (sp_q == SPW'(DEPTH));
    assign empty    = (sp_q == '0);

    // Return target; an empty stack falls back to instruction fetch.
    always_comb begin
        top = SW'(FETCH_STATE);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!empty && (SPW'(i) == sp_q - SPW'(1))) begin
                top = stack_q[i];
            end
        end
    end

    // Next micro-address, presented combinationally to the microstore.
    always_comb begin
        rom_addr = present_state_q;
        if (clr) begin
            rom_addr = SW'(RESET_STATE);
        end else if (!hold) begin
            case (ns_q)
                NS_DISPATCH: rom_addr = dispatch_addr;
                NS_FETCH:    rom_addr = SW'(FETCH_STATE);
                NS_JUMP:     rom_addr = cr_q;
                NS_INC:      rom_addr = inc;
                NS_BRANCH:   rom_addr = c ? cr_q : inc;
                NS_WAIT:     rom_addr = c ? inc : present_state_q;
                NS_CALL:     rom_addr = cr_q;
                NS_RET:      rom_addr = top;
                default:     rom_addr = present_state_q;
            endcase
        end
    end

    always_comb begin
        present_state_d = present_state_q;
        ctrl_d          = ctrl_q;
        ns_d            = ns_q;
        csel_d          = csel_q;
        inv_d           = inv_q;
        cr_d            = cr_q;
        stack_d         = stack_q;
        sp_d            = sp_q;
        ovf_d           = ovf_q;
        unf_d           = unf_q;
        if (!hold) begin
            present_state_d = rom_addr;
            ctrl_d          = uw_ctrl;
            ns_d            = uw_ns;
            csel_d          = uw_csel;
            inv_d           = uw_inv;
            cr_d            = uw_cr;
            // Overflowing calls still jump; only the return address is lost.
            if (ns_q == NS_CALL) begin
                if (!full) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (SPW'(i) == sp_q) begin
                            stack_d[i] = inc;
                        end
                    end
                    sp_d = sp_q + SPW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (ns_q == NS_RET) begin
                if (!empty) begin
                    sp_d = sp_q - SPW'(1);
                end else begin
                    unf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            present_state_q <= SW'(RESET_STATE);
            ctrl_q          <= '0;
            ns_q            <= NS_JUMP;
            csel_q          <= '0;
            inv_q           <= 1'b0;
            cr_q            <= SW'(RESET_STATE);
            sp_q            <= '0;
            ovf_q           <= 1'b0;
            unf_q           <= 1'b0;
        end else begin
            present_state_q <= present_state_d;
            ctrl_q          <= ctrl_d;
            ns_q            <= ns_d;
            csel_q          <= csel_d;
            inv_q           <= inv_d;
            cr_q            <= cr_d;
            stack_q         <= stack_d;
            sp_q            <= sp_d;
            ovf_q           <= ovf_d;
            unf_q           <= unf_d;
        end
    end

    assign present_state = present_state_q;
    assign ctrl          = ctrl_q;
    assign stack_level   = sp_q;
    assign stk_ovf       = ovf_q;
    assign stk_unf       = unf_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a small microprogram in a bench-side microstore,
// walked cycle by cycle from a vector table, plus hand-written reset/hold/wait sequences.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        hold;
    logic [4:0]  dispatch_addr;
    logic [3:0]  cond;
    logic [27:0] uw_ctrl;
    logic [2:0]  uw_ns;
    logic [1:0]  uw_csel;
    logic        uw_inv;
    logic [4:0]  uw_cr;
    logic [4:0]  rom_addr;
    logic [4:0]  present_state;
    logic [27:0] ctrl;
    logic [1:0]  stack_level;
    logic        stk_ovf;
    logic        stk_unf;

    micro_sequencer #(
        .SW(5), .CW(28), .NCOND(4), .CSW(2), .DEPTH(2), .FETCH_STATE(1), .RESET_STATE(0)
    ) dut (
        .clk(clk), .clr(clr), .hold(hold), .dispatch_addr(dispatch_addr), .cond(cond),
        .uw_ctrl(uw_ctrl), .uw_ns(uw_ns), .uw_csel(uw_csel), .uw_inv(uw_inv), .uw_cr(uw_cr),
        .rom_addr(rom_addr), .present_state(present_state), .ctrl(ctrl),
        .stack_level(stack_level), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    // Asynchronous microstore model
    logic [27:0] r_ctrl [32];
    logic [2:0]  r_ns   [32];
    logic [1:0]  r_csel [32];
    logic        r_inv  [32];
    logic [4:0]  r_cr   [32];

    assign uw_ctrl = r_ctrl[rom_addr];
    assign uw_ns   = r_ns[rom_addr];
    assign uw_csel = r_csel[rom_addr];
    assign uw_inv  = r_inv[rom_addr];
    assign uw_cr   = r_cr[rom_addr];

    function automatic logic [27:0] cw(input logic [4:0] a);
        return 28'hABC0000 + 28'(a);
    endfunction

    task automatic set_word(input int a, input logic [2:0] ns, input logic [1:0] cs,
                            input logic inv, input logic [4:0] cr);
        r_ns[a]   = ns;
        r_csel[a] = cs;
        r_inv[a]  = inv;
        r_cr[a]   = cr;
    endtask

    typedef struct {
        logic       clr;
        logic       hold;
        logic [3:0] cnd;
        logic [4:0] disp;
        logic [4:0] rom;
        logic [4:0] ps;
        logic       bub;
        logic [1:0] lvl;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vt[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic cl, input logic h, input logic [3:0] cn, input logic [4:0] d,
                       input logic [4:0] ra, input logic [4:0] ps, input logic bub,
                       input logic [1:0] lv, input logic o, input logic u);
        vec_t v;
        v.clr = cl; v.hold = h; v.cnd = cn; v.disp = d; v.rom = ra; v.ps = ps;
        v.bub = bub; v.lvl = lv; v.ovf = o; v.unf = u;
        vt.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h, want %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [4:0] ra, input logic [4:0] ps,
                           input logic [27:0] cexp, input logic [1:0] lv,
                           input logic o, input logic u);
        chk("rom_addr", idx, 32'(rom_addr), 32'(ra));
        chk("present_state", idx, 32'(present_state), 32'(ps));
        chk("ctrl", idx, 32'(ctrl), 32'(cexp));
        chk("stack_level", idx, 32'(stack_level), 32'(lv));
        chk("stk_ovf", idx, 32'(stk_ovf), 32'(o));
        chk("stk_unf", idx, 32'(stk_unf), 32'(u));
    endtask

    initial begin
        int cyc;
        clr = 1'b1; hold = 1'b0; dispatch_addr = '0; cond = 4'b0001;

        for (int a = 0; a < 32; a++) begin
            r_ctrl[a] = cw(5'(a));
            set_word(a, 3'b001, 2'd0, 1'b0, 5'd0);
        end
        set_word(0,  3'b011, 2'd0, 1'b0, 5'd0);
        set_word(1,  3'b000, 2'd0, 1'b0, 5'd0);
        set_word(2,  3'b111, 2'd0, 1'b0, 5'd0);
        set_word(3,  3'b110, 2'd0, 1'b0, 5'd10);
        set_word(4,  3'b010, 2'd0, 1'b0, 5'd12);
        set_word(5,  3'b101, 2'd1, 1'b0, 5'd0);
        set_word(6,  3'b101, 2'd1, 1'b1, 5'd0);
        set_word(7,  3'b011, 2'd0, 1'b0, 5'd0);
        set_word(8,  3'b100, 2'd2, 1'b0, 5'd20);
        set_word(9,  3'b100, 2'd2, 1'b1, 5'd20);
        set_word(10, 3'b110, 2'd0, 1'b0, 5'd15);
        set_word(11, 3'b111, 2'd0, 1'b0, 5'd0);
        set_word(12, 3'b110, 2'd0, 1'b0, 5'd14);
        set_word(13, 3'b010, 2'd0, 1'b0, 5'd31);
        set_word(14, 3'b110, 2'd0, 1'b0, 5'd16);
        set_word(15, 3'b111, 2'd0, 1'b0, 5'd0);
        set_word(16, 3'b110, 2'd0, 1'b0, 5'd17);
        set_word(17, 3'b111, 2'd0, 1'b0, 5'd0);
        set_word(20, 3'b001, 2'd0, 1'b0, 5'd0);
        set_word(31, 3'b011, 2'd0, 1'b0, 5'd0);

        //  clr hold cond     disp  rom  ps   bub lvl ovf unf
        add(1, 0, 4'b0001, 0,  0,  0,  1, 0, 0, 0);   // reset held second cycle
        add(0, 0, 4'b0001, 0,  0,  0,  1, 0, 0, 0);   // bubble
        add(0, 0, 4'b0001, 0,  1,  0,  0, 0, 0, 0);
        add(0, 0, 4'b0001, 13, 13, 1,  0, 0, 0, 0);   // dispatch
        add(0, 0, 4'b0001, 0,  31, 13, 0, 0, 0, 0);
        add(0, 0, 4'b0001, 0,  0,  31, 0, 0, 0, 0);   // increment wraps
        add(0, 0, 4'b0001, 0,  1,  0,  0, 0, 0, 0);
        add(0, 0, 4'b0001, 5,  5,  1,  0, 0, 0, 0);
        add(0, 0, 4'b0001, 0,  5,  5,  0, 0, 0, 0);   // wait on MOC low
        add(0, 0, 4'b0001, 0,  5,  5,  0, 0, 0, 0);
        add(0, 0, 4'b0001, 0,  5,  5,  0, 0, 0, 0);
        add(0, 0, 4'b0011, 0,  6,  5,  0, 0, 0, 0);   // MOC high exits
        add(0, 0, 4'b0011, 0,  6,  6,  0, 0, 0, 0);   // inverted wait
        add(0, 0, 4'b0011, 0,  6,  6,  0, 0, 0, 0);
        add(0, 0, 4'b0001, 0,  7,  6,  0, 0, 0, 0);
        add(0, 0, 4'b0001, 0,  8,  7,  0, 0, 0, 0);
        add(0, 0, 4'b0001, 0,  9,  8,  0, 0, 0, 0);   // branch not taken
        add(0, 0, 4'b0001, 0,  20, 9,  0, 0, 0, 0);   // inverted branch taken
        add(0, 0, 4'b0001, 0,  1,  20, 0, 0, 0, 0);
        add(0, 0, 4'b0001, 8,  8,  1,  0, 0, 0, 0);
        add(0, 0, 4'b0101, 0,  20, 8,  0, 0, 0, 0);   // branch taken
        add(0, 0, 4'b0001, 0,  1,  20, 0, 0, 0, 0);
        add(0, 0, 4'b0001, 3,  3,  1,  0, 0, 0, 0);
        add(0, 0, 4'b0001, 0,  10, 3,  0, 0, 0, 0);   // call
        add(0, 0, 4'b0001, 0,  15, 10, 0, 1, 0, 0);   // nested call
        add(0, 0, 4'b0001, 0,  11, 15, 0, 2, 0, 0);   // return
        add(0, 0, 4'b0001, 0,  4,  11, 0, 1, 0, 0);   // return
        add(0, 0, 4'b0001, 0,  12, 4,  0, 0, 0, 0);
        add(0, 0, 4'b0001, 0,  14, 12, 0, 0, 0, 0);
        add(0, 0, 4'b0001, 0,  16, 14, 0, 1, 0, 0);
        add(0, 0, 4'b0001, 0,  17, 16, 0, 2, 0, 0);   // call while full
        add(0, 0, 4'b0001, 0,  15, 17, 0, 2, 1, 0);
        add(0, 0, 4'b0001, 0,  13, 15, 0, 1, 1, 0);
        add(0, 0, 4'b0001, 0,  31, 13, 0, 0, 1, 0);
        add(0, 0, 4'b0001, 0,  0,  31, 0, 0, 1, 0);
        add(0, 0, 4'b0001, 0,  1,  0,  0, 0, 1, 0);
        add(0, 0, 4'b0001, 2,  2,  1,  0, 0, 1, 0);
        add(0, 0, 4'b0001, 0,  1,  2,  0, 0, 1, 0);   // return with empty stack
        add(0, 0, 4'b0001, 3,  3,  1,  0, 0, 1, 1);
        add(0, 0, 4'b0001, 0,  10, 3,  0, 0, 1, 1);
        add(0, 1, 4'b0011, 9,  10, 10, 0, 1, 1, 1);   // hold, inputs ignored
        add(0, 1, 4'b0111, 9,  10, 10, 0, 1, 1, 1);
        add(0, 1, 4'b0000, 9,  10, 10, 0, 1, 1, 1);
        add(0, 1, 4'b1111, 9,  10, 10, 0, 1, 1, 1);
        add(0, 0, 4'b0001, 0,  15, 10, 0, 1, 1, 1);   // resume
        add(0, 0, 4'b0001, 0,  11, 15, 0, 2, 1, 1);
        add(1, 0, 4'b0001, 0,  0,  11, 0, 1, 1, 1);   // reset mid-call
        add(0, 0, 4'b0001, 0,  0,  0,  1, 0, 0, 0);
        add(0, 0, 4'b0001, 0,  1,  0,  0, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < vt.size(); i++) begin
            clr = vt[i].clr; hold = vt[i].hold; cond = vt[i].cnd; dispatch_addr = vt[i].disp;
            #1;
            chk_all(i, vt[i].rom, vt[i].ps, vt[i].bub ? 28'h0 : cw(vt[i].ps),
                    vt[i].lvl, vt[i].ovf, vt[i].unf);
            @(negedge clk);
        end

        // clr wins over hold
        clr = 1'b1; hold = 1'b1; cond = 4'b0001; dispatch_addr = 5'd0;
        #1;
        chk("clr_hold_rom", 100, 32'(rom_addr), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("hold_after_clr_ps", 101, 32'(present_state), 32'd0);
        chk("hold_after_clr_ctrl", 101, 32'(ctrl), 32'd0);
        chk("hold_after_clr_rom", 101, 32'(rom_addr), 32'd0);
        @(negedge clk);
        hold = 1'b0;
        #1;
        chk("bubble_kept_ctrl", 102, 32'(ctrl), 32'd0);
        @(negedge clk);
        #1;
        chk("first_word_ctrl", 103, 32'(ctrl), 32'(cw(5'd0)));

        // Long MOC wait with bounded loops
        dispatch_addr = 5'd5;
        cyc = 0;
        while (present_state !== 5'd5 && cyc < 10) begin
            @(negedge clk); #1; cyc++;
        end
        chk("reach_wait_state", 104, 32'(present_state), 32'd5);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            chk("wait_hold_ctrl", 105 + k, 32'(ctrl), 32'(cw(5'd5)));
        end
        cond = 4'b0011;
        #1;
        chk("wait_exit_rom", 111, 32'(rom_addr), 32'd6);
        cyc = 0;
        while (present_state !== 5'd6 && cyc < 4) begin
            @(negedge clk); #1; cyc++;
        end
        chk("wait_exit_ps", 112, 32'(present_state), 32'd6);
        chk("wait_exit_cycles", 112, 32'(cyc), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
